fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch end of the IF/ID interface. Owns the PC and issues word requests to instruction memory.
- Registers each returned instruction plus PC+4 into the IF/ID register that drives the decode stage's instruccion input.
- Handles decode-side stalls with a one-entry skid buffer.
- Handles taken-branch redirects, including dropping an in-flight memory response.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- stall  in  1  hold IF/ID contents; decode cannot accept a new instruction.
- branch_taken  in  1  redirect fetch; flush IF/ID.
- branch_target  in  32  redirect address, word aligned, sampled when branch_taken=1.
- imem_req  out  1  memory request valid.
- imem_addr  out  32  memory word address (byte address, [1:0]=0).
- imem_ready  in  1  memory response valid for the current request, same cycle.
- imem_rdata  in  32  instruction word, valid when imem_req&imem_ready.
- instruccion  out  32  IF/ID instruction register.
- pc_plus4  out  32  IF/ID PC+4 register.
- if_valid  out  1  IF/ID contents are a real instruction.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=IDLE.
  - instruccion=0 (NOP), pc_plus4=0, if_valid=0, buffer cleared.
  - imem_req=0, imem_addr=RESET_PC.
- Handshake:
  - A transfer completes on a rising edge with imem_req=1 and imem_ready=1.
  - While imem_req=1 and imem_ready=0, imem_addr is held stable. No request is abandoned once issued.
- imem_req and imem_addr are decoded from state: imem_req=1 in FETCH and DROP, imem_addr=pc.
- IDLE:
  - Unconditionally goes to FETCH on the next edge.
  - branch_taken is ignored in IDLE.
- FETCH:
  - branch_taken=1 (highest priority):
    - IF/ID flushes: instruccion=0, if_valid=0, pc_plus4 unchanged.
    - If imem_ready=1: the returned word is discarded, pc<=branch_target, stay in FETCH.
    - If imem_ready=0: redir<=branch_target, go to DROP.
  - Else imem_ready=1 and stall=0:
    - instruccion<=imem_rdata, pc_plus4<=pc+4, if_valid<=1.
    - pc<=pc+4.
  - Else imem_ready=1 and stall=1:
    - buf_instr<=imem_rdata, buf_pc4<=pc+4, pc<=pc+4, go to FULL.
    - IF/ID holds.
  - Else imem_ready=0:
    - If stall=0: if_valid<=0 (bubble), instruccion<=0.
    - If stall=1: IF/ID holds.
- FULL:
  - imem_req=0.
  - branch_taken=1: buffer dropped, IF/ID flushed, pc<=branch_target, go to FETCH.
  - Else stall=0: IF/ID<=buffer, if_valid<=1, go to FETCH.
  - Else stall=1: hold.
- DROP:
  - imem_req=1 at the old pc until imem_ready.
  - On imem_ready: the word is discarded, pc<=redir, go to FETCH.
  - Further branch_taken in DROP: redir<=latest branch_target, IF/ID stays flushed.
  - if_valid stays 0 throughout DROP.
- Priority: branch_taken > stall > normal advance. stall never blocks a flush.
- Latency:
  - With imem_ready tied 1 and no stall, address A issued in cycle n appears in IF/ID after edge n+1.
  - Throughput is 1 instruction/cycle.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- An instruction is never duplicated or lost across stall/unstall.
- Reset mid-transfer: returns immediately to the reset state; any pending response is ignored after reset release.

Test Plan:
1. Reset release, imem_ready=1, memory returns addr>>2 as data:
   - imem_addr sequence 0,4,8,C.
   - IF/ID gets instruccion 0,1,2,3, pc_plus4 4,8,C,10.
   - if_valid=1 from the second edge after IDLE.
2. stall=1 for 3 cycles starting when IF/ID holds word 1, imem_ready=1:
   - One extra word (2) goes to the buffer, FULL, imem_req=0.
   - IF/ID holds 1 for 3 cycles.
   - After release, IF/ID shows 2, then 3; no duplicate and no gap.
3. branch_taken=1, branch_target=32'h40 with imem_ready=1 in FETCH:
   - Next edge if_valid=0, instruccion=0.
   - Next imem_addr=0x40; IF/ID then shows the word from 0x40 with pc_plus4=0x44.
4. imem_ready=0 for 4 cycles at addr 0x8 while branch_taken pulses (target 0x100, then 0x200 a cycle later):
   - imem_addr stays 0x8 until ready; that word is discarded.
   - Next imem_addr=0x200.
5. branch_taken=1 while in FULL with stall=1:
   - Buffered word is dropped, if_valid=0, next imem_addr=branch_target.
6. RESET_PC=32'hFFFF_FFFC:
   - pc_plus4 for the first word is 0.
   - Second imem_addr=0.
   - Asserting rst low mid-wait forces imem_req=0 and if_valid=0 immediately (asynchronous).

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, requests words from imem and fills IF/ID.
// A one-entry skid buffer absorbs decode stalls; redirects can drop an in-flight word.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruccion,
   output logic [31:0] pc_plus4,
   output logic        if_valid
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      FULL,
      DROP
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] redir_q, redir_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc4_q, buf_pc4_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_inc;

   assign pc_inc      = pc_q + 32'd4;
   assign imem_req    = (state_q == FETCH) || (state_q == DROP);
   assign imem_addr   = pc_q;
   assign instruccion = instr_q;
   assign pc_plus4    = pc4_q;
   assign if_valid    = valid_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      redir_d     = redir_q;
      buf_instr_d = buf_instr_q;
      buf_pc4_d   = buf_pc4_q;
      instr_d     = instr_q;
      pc4_d       = pc4_q;
      valid_d     = valid_q;
      unique case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (branch_taken) begin
               instr_d = 32'd0;
               valid_d = 1'b0;
               if (imem_ready) begin
                  pc_d = branch_target;
               end else begin
                  redir_d = branch_target;
                  state_d = DROP;
               end
            end else if (imem_ready && !stall) begin
               instr_d = imem_rdata;
               pc4_d   = pc_inc;
               valid_d = 1'b1;
               pc_d    = pc_inc;
            end else if (imem_ready) begin
               buf_instr_d = imem_rdata;
               buf_pc4_d   = pc_inc;
               pc_d        = pc_inc;
               state_d     = FULL;
            end else if (!stall) begin
               instr_d = 32'd0;
               valid_d = 1'b0;
            end
         end
         FULL: begin
            if (branch_taken) begin
               instr_d = 32'd0;
               valid_d = 1'b0;
               pc_d    = branch_target;
               state_d = FETCH;
            end else if (!stall) begin
               instr_d = buf_instr_q;
               pc4_d   = buf_pc4_q;
               valid_d = 1'b1;
               state_d = FETCH;
            end
         end
         DROP: begin
            instr_d = 32'd0;
            valid_d = 1'b0;
            if (branch_taken) begin
               redir_d = branch_target;
            end
            // A branch arriving with the response still wins over the stored one
            if (imem_ready) begin
               pc_d    = branch_taken ? branch_target : redir_q;
               state_d = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         redir_q     <= 32'd0;
         buf_instr_q <= 32'd0;
         buf_pc4_q   <= 32'd0;
         instr_q     <= 32'd0;
         pc4_q       <= 32'd0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         redir_q     <= redir_d;
         buf_instr_q <= buf_instr_d;
         buf_pc4_q   <= buf_pc4_d;
         instr_q     <= instr_d;
         pc4_q       <= pc4_d;
         valid_q     <= valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle expectations queued by each scenario,
// compared by a monitor just after every rising edge.
module tb_fetch_stage;

   typedef struct packed {
      logic        sel;
      logic        req;
      logic [31:0] addr;
      logic        v;
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, stall, br, rdy;
   logic [31:0] tgt, rdata, addr, instr, pc4;
   logic        req, v;
   logic        rst2, stall2, br2, rdy2;
   logic [31:0] tgt2, rdata2, addr2, instr2, pc42;
   logic        req2, v2;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   string       cur = "none";

   always #5 clk = ~clk;

   // Memory returns the word index as data
   assign rdata  = addr >> 2;
   assign rdata2 = addr2 >> 2;

   fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rst(rst), .stall(stall),
      .branch_taken(br), .branch_target(tgt),
      .imem_req(req), .imem_addr(addr),
      .imem_ready(rdy), .imem_rdata(rdata),
      .instruccion(instr), .pc_plus4(pc4), .if_valid(v)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
      .clk(clk), .rst(rst2), .stall(stall2),
      .branch_taken(br2), .branch_target(tgt2),
      .imem_req(req2), .imem_addr(addr2),
      .imem_ready(rdy2), .imem_rdata(rdata2),
      .instruccion(instr2), .pc_plus4(pc42), .if_valid(v2)
   );

   always @(posedge clk) begin
      exp_t        e;
      logic        o_req, o_v;
      logic [31:0] o_addr, o_instr, o_pc4;
      #1;
      if (sb.size() > 0) begin
         e       = sb.pop_front();
         o_req   = e.sel ? req2   : req;
         o_addr  = e.sel ? addr2  : addr;
         o_v     = e.sel ? v2     : v;
         o_instr = e.sel ? instr2 : instr;
         o_pc4   = e.sel ? pc42   : pc4;
         vectors += 5;
         if (o_req !== e.req) begin
            miscompares++;
            $display("FAIL %s imem_req got %b want %b", cur, o_req, e.req);
         end
         if (o_addr !== e.addr) begin
            miscompares++;
            $display("FAIL %s imem_addr got %h want %h", cur, o_addr, e.addr);
         end
         if (o_v !== e.v) begin
            miscompares++;
            $display("FAIL %s if_valid got %b want %b", cur, o_v, e.v);
         end
         if (o_instr !== e.instr) begin
            miscompares++;
            $display("FAIL %s instruccion got %h want %h", cur, o_instr, e.instr);
         end
         if (o_pc4 !== e.pc4) begin
            miscompares++;
            $display("FAIL %s pc_plus4 got %h want %h", cur, o_pc4, e.pc4);
         end
      end
   end

   task automatic ex(input logic s, input logic rq, input logic [31:0] a,
                     input logic vv, input logic [31:0] i, input logic [31:0] p);
      exp_t e;
      e = '{sel: s, req: rq, addr: a, v: vv, instr: i, pc4: p};
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst   = 1'b0;
      stall = 1'b0;
      br    = 1'b0;
      tgt   = 32'd0;
      rdy   = 1'b1;
      tick();
      rst = 1'b1;
      ex(0, 1, 32'h0, 0, 32'h0, 32'h0);
      tick();
   endtask

   task automatic test_reset();
      cur = "reset";
      #1;
      vectors += 5;
      if (req !== 1'b0) begin
         miscompares++;
         $display("FAIL %s imem_req got %b want 0", cur, req);
      end
      if (addr !== 32'h0) begin
         miscompares++;
         $display("FAIL %s imem_addr got %h want 0", cur, addr);
      end
      if (v !== 1'b0) begin
         miscompares++;
         $display("FAIL %s if_valid got %b want 0", cur, v);
      end
      if (instr !== 32'h0) begin
         miscompares++;
         $display("FAIL %s instruccion got %h want 0", cur, instr);
      end
      if (pc4 !== 32'h0) begin
         miscompares++;
         $display("FAIL %s pc_plus4 got %h want 0", cur, pc4);
      end
   endtask

   task automatic test_stream();
      cur = "stream";
      do_reset();
      ex(0, 1, 32'h4, 1, 32'h0, 32'h4);    tick();
      ex(0, 1, 32'h8, 1, 32'h1, 32'h8);    tick();
      ex(0, 1, 32'hC, 1, 32'h2, 32'hC);    tick();
      ex(0, 1, 32'h10, 1, 32'h3, 32'h10);  tick();
   endtask

   task automatic test_stall();
      cur = "stall";
      do_reset();
      ex(0, 1, 32'h4, 1, 32'h0, 32'h4);  tick();
      ex(0, 1, 32'h8, 1, 32'h1, 32'h8);  tick();
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ex(0, 0, 32'hC, 1, 32'h1, 32'h8);
         tick();
      end
      stall = 1'b0;
      ex(0, 1, 32'hC, 1, 32'h2, 32'hC);    tick();
      ex(0, 1, 32'h10, 1, 32'h3, 32'h10);  tick();
   endtask

   task automatic test_branch_ready();
      cur = "branch_ready";
      do_reset();
      ex(0, 1, 32'h4, 1, 32'h0, 32'h4);  tick();
      br  = 1'b1;
      tgt = 32'h40;
      ex(0, 1, 32'h40, 0, 32'h0, 32'h4);  tick();
      br = 1'b0;
      ex(0, 1, 32'h44, 1, 32'h10, 32'h44);  tick();
   endtask

   task automatic test_branch_drop();
      cur = "branch_drop";
      do_reset();
      ex(0, 1, 32'h4, 1, 32'h0, 32'h4);  tick();
      ex(0, 1, 32'h8, 1, 32'h1, 32'h8);  tick();
      rdy = 1'b0;
      ex(0, 1, 32'h8, 0, 32'h0, 32'h8);  tick();
      br  = 1'b1;
      tgt = 32'h100;
      ex(0, 1, 32'h8, 0, 32'h0, 32'h8);  tick();
      tgt = 32'h200;
      ex(0, 1, 32'h8, 0, 32'h0, 32'h8);  tick();
      br = 1'b0;
      ex(0, 1, 32'h8, 0, 32'h0, 32'h8);  tick();
      rdy = 1'b1;
      ex(0, 1, 32'h200, 0, 32'h0, 32'h8);    tick();
      ex(0, 1, 32'h204, 1, 32'h80, 32'h204);  tick();
   endtask

   task automatic test_branch_full();
      cur = "branch_full";
      do_reset();
      ex(0, 1, 32'h4, 1, 32'h0, 32'h4);  tick();
      stall = 1'b1;
      ex(0, 0, 32'h8, 1, 32'h0, 32'h4);  tick();
      br  = 1'b1;
      tgt = 32'h80;
      ex(0, 1, 32'h80, 0, 32'h0, 32'h4);  tick();
      br    = 1'b0;
      stall = 1'b0;
      ex(0, 1, 32'h84, 1, 32'h20, 32'h84);  tick();
   endtask

   task automatic test_wrap_async();
      cur = "wrap";
      rst  = 1'b0;
      rdy2 = 1'b1;
      tick();
      rst2 = 1'b1;
      ex(1, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);         tick();
      ex(1, 1, 32'h0, 1, 32'h3FFF_FFFF, 32'h0);         tick();
      ex(1, 1, 32'h4, 1, 32'h0, 32'h4);                 tick();
      rdy2 = 1'b0;
      ex(1, 1, 32'h4, 0, 32'h0, 32'h4);                 tick();
      cur = "async_reset";
      #2;
      rst2 = 1'b0;
      #1;
      vectors += 4;
      if (req2 !== 1'b0) begin
         miscompares++;
         $display("FAIL %s imem_req got %b want 0", cur, req2);
      end
      if (v2 !== 1'b0) begin
         miscompares++;
         $display("FAIL %s if_valid got %b want 0", cur, v2);
      end
      if (addr2 !== 32'hFFFF_FFFC) begin
         miscompares++;
         $display("FAIL %s imem_addr got %h want fffffffc", cur, addr2);
      end
      if (pc42 !== 32'h0) begin
         miscompares++;
         $display("FAIL %s pc_plus4 got %h want 0", cur, pc42);
      end
      tick();
      rst2 = 1'b1;
      ex(1, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);  tick();
      rdy2 = 1'b1;
      ex(1, 1, 32'h0, 1, 32'h3FFF_FFFF, 32'h0);  tick();
   endtask

   initial begin
      rst    = 1'b0;
      stall  = 1'b0;
      br     = 1'b0;
      tgt    = 32'd0;
      rdy    = 1'b1;
      rst2   = 1'b0;
      stall2 = 1'b0;
      br2    = 1'b0;
      tgt2   = 32'd0;
      rdy2   = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_branch_ready();
      test_branch_drop();
      test_branch_full();
      test_wrap_async();
      tick();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain queue got %0d want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
